// File: rtl/imuldiv_div_frontend_pkg.sv
// Shared encodings for the divider front-end: pipeline fn codes, divider fn codes,
// FSM state encodings and the response half-select helper.
package imuldiv_div_frontend_pkg;

    localparam logic [1:0] FN_DIV  = 2'd0;
    localparam logic [1:0] FN_DIVU = 2'd1;
    localparam logic [1:0] FN_REM  = 2'd2;
    localparam logic [1:0] FN_REMU = 2'd3;

    localparam int FN_UNSIGNED_BIT = 0;
    localparam int FN_REM_BIT      = 1;

    // Same values as IMULDIV_DIVREQ_MSG_FUNC_SIGNED / _UNSIGNED in the DivReqMsg header
    localparam logic DIVREQ_FUNC_SIGNED   = 1'b0;
    localparam logic DIVREQ_FUNC_UNSIGNED = 1'b1;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [31:0] select_half(input logic [63:0] resp, input logic want_rem);
        return want_rem ? resp[63:32] : resp[31:0];
    endfunction

endpackage

// File: rtl/imuldiv_div_frontend_if.sv
// Handshake bundle tying the muldiv issue port, the divider front-end and the
// iterative divider. master = pipeline/divider side, slave = front-end.
interface imuldiv_div_frontend_if;

    logic [1:0]  req_msg_fn;
    logic [31:0] req_msg_a;
    logic [31:0] req_msg_b;
    logic        req_val;
    logic        req_rdy;

    logic [31:0] resp_msg_result;
    logic        resp_val;
    logic        resp_rdy;

    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a;
    logic [31:0] divreq_msg_b;
    logic        divreq_val;
    logic        divreq_rdy;

    logic [63:0] divresp_msg_result;
    logic        divresp_val;
    logic        divresp_rdy;

    modport master (
        output req_msg_fn, req_msg_a, req_msg_b, req_val, resp_rdy,
               divreq_rdy, divresp_msg_result, divresp_val,
        input  req_rdy, resp_msg_result, resp_val,
               divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy
    );

    modport slave (
        input  req_msg_fn, req_msg_a, req_msg_b, req_val, resp_rdy,
               divreq_rdy, divresp_msg_result, divresp_val,
        output req_rdy, resp_msg_result, resp_val,
               divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy
    );

endinterface

// File: rtl/imuldiv_div_frontend_ctrl.sv
// Front-end FSM: IDLE -> ISSUE -> WAIT -> RESP, with a direct IDLE -> RESP shortcut
// for locally resolved requests. All handshake outputs are registered.
module imuldiv_div_frontend_ctrl
    import imuldiv_div_frontend_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_val_i,
    input  logic b_zero_i,
    input  logic reuse_hit_i,
    input  logic divreq_rdy_i,
    input  logic divresp_val_i,
    input  logic resp_rdy_i,
    output logic req_rdy_o,
    output logic resp_val_o,
    output logic divreq_val_o,
    output logic divresp_rdy_o,
    output logic accept_o,
    output logic capture_o
);

    state_e state_q;
    logic   req_rdy_q;
    logic   resp_val_q;
    logic   divreq_val_q;
    logic   divresp_rdy_q;

    assign accept_o      = req_val_i & req_rdy_q;
    assign capture_o     = divresp_val_i & divresp_rdy_q;
    assign req_rdy_o     = req_rdy_q;
    assign resp_val_o    = resp_val_q;
    assign divreq_val_o  = divreq_val_q;
    assign divresp_rdy_o = divresp_rdy_q;

    // Each transition also sets the handshake outputs of the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            req_rdy_q     <= 1'b1;
            resp_val_q    <= 1'b0;
            divreq_val_q  <= 1'b0;
            divresp_rdy_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_o) begin
                        req_rdy_q <= 1'b0;
                        if (b_zero_i || reuse_hit_i) begin
                            state_q    <= ST_RESP;
                            resp_val_q <= 1'b1;
                        end else begin
                            state_q      <= ST_ISSUE;
                            divreq_val_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (divreq_rdy_i) begin
                        state_q       <= ST_WAIT;
                        divreq_val_q  <= 1'b0;
                        divresp_rdy_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (capture_o) begin
                        state_q       <= ST_RESP;
                        divresp_rdy_q <= 1'b0;
                        resp_val_q    <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_rdy_i) begin
                        state_q    <= ST_IDLE;
                        resp_val_q <= 1'b0;
                        req_rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    req_rdy_q     <= 1'b1;
                    resp_val_q    <= 1'b0;
                    divreq_val_q  <= 1'b0;
                    divresp_rdy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/imuldiv_div_frontend.sv
// Divider request front-end: operand/result registers and selection muxes around the
// control FSM. Define IMULDIV_DIV_FRONTEND_REUSE_EN to reuse the last divider result.
module imuldiv_div_frontend
    import imuldiv_div_frontend_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    imuldiv_div_frontend_if.slave  bus
);

    logic [1:0]  fn_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] result_q;
    logic [31:0] result_d;

    logic        b_zero_s;
    logic        reuse_hit_s;
    logic [31:0] reuse_sel_s;
    logic        accept_s;
    logic        capture_s;

    assign b_zero_s = (bus.req_msg_b == 32'd0);

    imuldiv_div_frontend_ctrl u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .req_val_i     (bus.req_val),
        .b_zero_i      (b_zero_s),
        .reuse_hit_i   (reuse_hit_s),
        .divreq_rdy_i  (bus.divreq_rdy),
        .divresp_val_i (bus.divresp_val),
        .resp_rdy_i    (bus.resp_rdy),
        .req_rdy_o     (bus.req_rdy),
        .resp_val_o    (bus.resp_val),
        .divreq_val_o  (bus.divreq_val),
        .divresp_rdy_o (bus.divresp_rdy),
        .accept_o      (accept_s),
        .capture_o     (capture_s)
    );

    // Operands are only meaningful while a request is in flight, so no reset
    always_ff @(posedge clk) begin
        if (accept_s) begin
            fn_q <= bus.req_msg_fn;
            a_q  <= bus.req_msg_a;
            b_q  <= bus.req_msg_b;
        end
    end

    always_comb begin
        result_d = result_q;
        if (accept_s && b_zero_s) begin
            result_d = bus.req_msg_fn[FN_REM_BIT] ? bus.req_msg_a : DIV0_QUOTIENT;
        end else if (accept_s && reuse_hit_s) begin
            result_d = reuse_sel_s;
        end else if (capture_s) begin
            result_d = select_half(bus.divresp_msg_result, fn_q[FN_REM_BIT]);
        end else begin
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        result_q <= result_d;
    end

`ifdef IMULDIV_DIV_FRONTEND_REUSE_EN
    logic        reuse_vld_q;
    logic        reuse_uns_q;
    logic [31:0] reuse_a_q;
    logic [31:0] reuse_b_q;
    logic [63:0] reuse_resp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            reuse_vld_q <= 1'b0;
        end else if (capture_s) begin
            reuse_vld_q <= 1'b1;
        end
    end

    // Entry is refreshed only from real divider responses; zero-divides never reach here
    always_ff @(posedge clk) begin
        if (capture_s) begin
            reuse_a_q    <= a_q;
            reuse_b_q    <= b_q;
            reuse_uns_q  <= fn_q[FN_UNSIGNED_BIT];
            reuse_resp_q <= bus.divresp_msg_result;
        end
    end

    assign reuse_hit_s = reuse_vld_q
                       && (bus.req_msg_a == reuse_a_q)
                       && (bus.req_msg_b == reuse_b_q)
                       && (bus.req_msg_fn[FN_UNSIGNED_BIT] == reuse_uns_q);
    assign reuse_sel_s = select_half(reuse_resp_q, bus.req_msg_fn[FN_REM_BIT]);
`else
    assign reuse_hit_s = 1'b0;
    assign reuse_sel_s = 32'd0;
`endif

    assign bus.divreq_msg_fn   = fn_q[FN_UNSIGNED_BIT] ? DIVREQ_FUNC_UNSIGNED : DIVREQ_FUNC_SIGNED;
    assign bus.divreq_msg_a    = a_q;
    assign bus.divreq_msg_b    = b_q;
    assign bus.resp_msg_result = result_q;

endmodule

// File: tb/tb_imuldiv_div_frontend.sv
// Directed bench for imuldiv_div_frontend with a behavioural iterative-divider peer.
module tb_imuldiv_div_frontend;
    import imuldiv_div_frontend_pkg::*;

`ifdef IMULDIV_DIV_FRONTEND_REUSE_EN
    localparam int REPEAT_NDIV = 0;
`else
    localparam int REPEAT_NDIV = 1;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   div_lat;
    int   stall_req;
    int   n_divreq;
    logic last_fn;

    imuldiv_div_frontend_if bus ();

    imuldiv_div_frontend dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input logic uns);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (uns) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Divider peer: acts at #2 after each edge on handshakes recorded for that edge
    initial begin : divider_model
        logic        fire_req;
        logic        fire_resp;
        logic        rst_seen;
        logic        busy;
        logic        seen_issue;
        logic [63:0] res;
        int          cnt;
        int          stall_left;
        fire_req = 1'b0; fire_resp = 1'b0; rst_seen = 1'b1; busy = 1'b0;
        seen_issue = 1'b0; res = 64'd0; cnt = 0; stall_left = 0;
        n_divreq = 0; last_fn = 1'b0;
        bus.divreq_rdy = 1'b0;
        bus.divresp_val = 1'b0;
        bus.divresp_msg_result = 64'd0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_seen) begin
                busy = 1'b0;
                seen_issue = 1'b0;
                bus.divreq_rdy = 1'b0;
                bus.divresp_val = 1'b0;
            end else begin
                if (fire_resp) begin
                    bus.divresp_val = 1'b0;
                    busy = 1'b0;
                end
                if (fire_req) begin
                    busy = 1'b1;
                    seen_issue = 1'b0;
                    cnt = div_lat;
                end
                if (busy && !bus.divresp_val) begin
                    if (cnt <= 0) begin
                        bus.divresp_val = 1'b1;
                        bus.divresp_msg_result = res;
                    end else begin
                        cnt = cnt - 1;
                    end
                end
                if (bus.divreq_val && !busy && !seen_issue) begin
                    seen_issue = 1'b1;
                    stall_left = stall_req;
                end
                if (bus.divreq_val && !busy && stall_left > 0) begin
                    stall_left = stall_left - 1;
                    bus.divreq_rdy = 1'b0;
                end else begin
                    bus.divreq_rdy = bus.divreq_val && !busy;
                end
            end
            rst_seen  = reset;
            fire_req  = bus.divreq_val && bus.divreq_rdy && !reset;
            fire_resp = bus.divresp_val && bus.divresp_rdy && !reset;
            if (fire_req) begin
                n_divreq = n_divreq + 1;
                last_fn  = bus.divreq_msg_fn;
                res = model_div(bus.divreq_msg_a, bus.divreq_msg_b,
                                bus.divreq_msg_fn == DIVREQ_FUNC_UNSIGNED);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_req(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
        int waited;
        waited = 0;
        bus.req_msg_fn = fn;
        bus.req_msg_a  = a;
        bus.req_msg_b  = b;
        bus.req_val    = 1'b1;
        while (!bus.req_rdy && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.req_rdy) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout req_rdy=%0b required 1", bus.req_rdy);
        end
        @(posedge clk); #1;
        bus.req_val   = 1'b0;
        bus.req_msg_a = 32'hDEAD_BEEF;
        bus.req_msg_b = 32'h0BAD_F00D;
    endtask

    task automatic wait_resp(output logic [31:0] res, output int lat);
        lat = 1;
        while (!bus.resp_val && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.resp_val) begin
            n_tests++; n_fail++;
            $display("FAIL resp_timeout resp_val=%0b required 1", bus.resp_val);
        end
        res = bus.resp_msg_result;
    endtask

    task automatic finish_resp();
        bus.resp_rdy = 1'b1;
        @(posedge clk); #1;
        bus.resp_rdy = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int ndiv);
        int n0;
        n0 = n_divreq;
        send_req(fn, a, b);
        wait_resp(res, lat);
        finish_resp();
        ndiv = n_divreq - n0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_req_rdy got %0b want 1", bus.req_rdy); end
        n_tests++; if (bus.resp_val !== 1'b0) begin n_fail++; $display("FAIL reset_resp_val got %0b want 0", bus.resp_val); end
        n_tests++; if (bus.divreq_val !== 1'b0) begin n_fail++; $display("FAIL reset_divreq_val got %0b want 0", bus.divreq_val); end
        n_tests++; if (bus.divresp_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_divresp_rdy got %0b want 0", bus.divresp_rdy); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] res; int lat; int ndiv;
        do_op(FN_DIV, 32'd100, 32'd7, res, lat, ndiv);
        n_tests++; if (res !== 32'd14) begin n_fail++; $display("FAIL div_100_7 got %h want %h", res, 32'd14); end
        n_tests++; if (ndiv != 1) begin n_fail++; $display("FAIL div_100_7_issues got %0d want 1", ndiv); end
        n_tests++; if (last_fn !== DIVREQ_FUNC_SIGNED) begin n_fail++; $display("FAIL div_100_7_fn got %0b want %0b", last_fn, DIVREQ_FUNC_SIGNED); end
        do_op(FN_REM, 32'd100, 32'd7, res, lat, ndiv);
        n_tests++; if (res !== 32'd2) begin n_fail++; $display("FAIL rem_100_7 got %h want %h", res, 32'd2); end
        n_tests++; if (ndiv != REPEAT_NDIV) begin n_fail++; $display("FAIL rem_100_7_issues got %0d want %0d", ndiv, REPEAT_NDIV); end
    endtask

    task automatic test_signed();
        logic [31:0] res; int lat; int ndiv;
        do_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, ndiv);
        n_tests++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_m7_2 got %h want fffffffd", res); end
        do_op(FN_REM, 32'hFFFF_FFF9, 32'd2, res, lat, ndiv);
        n_tests++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_m7_2 got %h want ffffffff", res); end
        do_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, ndiv);
        n_tests++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL div_overflow got %h want 80000000", res); end
        n_tests++; if (ndiv != 1) begin n_fail++; $display("FAIL div_overflow_issues got %0d want 1", ndiv); end
        do_op(FN_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, ndiv);
        n_tests++; if (res !== 32'd0) begin n_fail++; $display("FAIL rem_overflow got %h want 0", res); end
    endtask

    task automatic test_unsigned();
        logic [31:0] res; int lat; int ndiv;
        do_op(FN_REMU, 32'hFFFF_FFFF, 32'd16, res, lat, ndiv);
        n_tests++; if (res !== 32'd15) begin n_fail++; $display("FAIL remu_ffffffff_16 got %h want f", res); end
        n_tests++; if (last_fn !== DIVREQ_FUNC_UNSIGNED) begin n_fail++; $display("FAIL remu_fn got %0b want %0b", last_fn, DIVREQ_FUNC_UNSIGNED); end
        do_op(FN_DIVU, 32'hFFFF_FFFF, 32'd16, res, lat, ndiv);
        n_tests++; if (res !== 32'h0FFF_FFFF) begin n_fail++; $display("FAIL divu_ffffffff_16 got %h want 0fffffff", res); end
        n_tests++; if (ndiv != REPEAT_NDIV) begin n_fail++; $display("FAIL divu_repeat_issues got %0d want %0d", ndiv, REPEAT_NDIV); end
    endtask

    task automatic test_zero_div();
        logic [31:0] res; int lat; int ndiv;
        do_op(FN_DIVU, 32'd5, 32'd0, res, lat, ndiv);
        n_tests++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_5_0 got %h want ffffffff", res); end
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL divu_5_0_latency got %0d want 1", lat); end
        n_tests++; if (ndiv != 0) begin n_fail++; $display("FAIL divu_5_0_issues got %0d want 0", ndiv); end
        do_op(FN_REM, 32'd5, 32'd0, res, lat, ndiv);
        n_tests++; if (res !== 32'd5) begin n_fail++; $display("FAIL rem_5_0 got %h want 5", res); end
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL rem_5_0_latency got %0d want 1", lat); end
        n_tests++; if (ndiv != 0) begin n_fail++; $display("FAIL rem_5_0_issues got %0d want 0", ndiv); end
    endtask

    task automatic test_backpressure();
        logic [31:0] res; int lat;
        send_req(FN_DIVU, 32'd1000, 32'd10);
        wait_resp(res, lat);
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (bus.resp_val !== 1'b1) begin n_fail++; $display("FAIL bp_resp_val cyc %0d got %0b want 1", i, bus.resp_val); end
            n_tests++; if (bus.resp_msg_result !== 32'd100) begin n_fail++; $display("FAIL bp_result cyc %0d got %h want 64", i, bus.resp_msg_result); end
            n_tests++; if (bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_req_rdy cyc %0d got %0b want 0", i, bus.req_rdy); end
            @(posedge clk); #1;
        end
        finish_resp();
        n_tests++; if (bus.resp_val !== 1'b0 || bus.req_rdy !== 1'b1) begin
            n_fail++; $display("FAIL bp_release resp_val=%0b req_rdy=%0b want 0 1", bus.resp_val, bus.req_rdy);
        end
    endtask

    task automatic test_issue_stall();
        logic [31:0] res; int lat;
        stall_req = 3;
        send_req(FN_DIV, 32'hFFFF_FF9C, 32'd7);
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (bus.divreq_val !== 1'b1) begin n_fail++; $display("FAIL stall_divreq_val cyc %0d got %0b want 1", i, bus.divreq_val); end
            n_tests++; if (bus.divresp_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_divresp_rdy cyc %0d got %0b want 0", i, bus.divresp_rdy); end
            n_tests++; if (bus.divreq_msg_a !== 32'hFFFF_FF9C || bus.divreq_msg_b !== 32'd7 || bus.divreq_msg_fn !== DIVREQ_FUNC_SIGNED) begin
                n_fail++; $display("FAIL stall_divreq_msg cyc %0d got %h %h %0b want ffffff9c 7 0", i,
                                   bus.divreq_msg_a, bus.divreq_msg_b, bus.divreq_msg_fn);
            end
            @(posedge clk); #1;
        end
        wait_resp(res, lat);
        finish_resp();
        stall_req = 0;
        n_tests++; if (res !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL div_m100_7 got %h want fffffff2", res); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] res; int lat; int ndiv; int waited;
        div_lat = 20;
        send_req(FN_DIVU, 32'd50, 32'd5);
        waited = 0;
        while (!bus.divresp_rdy && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        n_tests++; if (bus.divresp_rdy !== 1'b1) begin n_fail++; $display("FAIL wait_reached divresp_rdy=%0b want 1", bus.divresp_rdy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_tests++; if (bus.req_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_wait_req_rdy got %0b want 1", bus.req_rdy); end
        n_tests++; if (bus.resp_val !== 1'b0) begin n_fail++; $display("FAIL rst_wait_resp_val got %0b want 0", bus.resp_val); end
        n_tests++; if (bus.divresp_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_wait_divresp_rdy got %0b want 0", bus.divresp_rdy); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus.resp_val !== 1'b0) begin n_fail++; $display("FAIL rst_wait_spurious_resp got %0b want 0", bus.resp_val); end
        div_lat = 2;
        do_op(FN_DIV, 32'd9, 32'd3, res, lat, ndiv);
        n_tests++; if (res !== 32'd3) begin n_fail++; $display("FAIL div_9_3 got %h want 3", res); end
        n_tests++; if (ndiv != 1) begin n_fail++; $display("FAIL div_9_3_issues got %0d want 1", ndiv); end
    endtask

`ifdef IMULDIV_DIV_FRONTEND_REUSE_EN
    task automatic test_reuse();
        logic [31:0] res; int lat; int ndiv;
        pulse_reset();
        do_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, ndiv);
        n_tests++; if (res !== 32'hFFFF_FFFD || ndiv != 1) begin n_fail++; $display("FAIL reuse_first got %h/%0d want fffffffd/1", res, ndiv); end
        do_op(FN_REM, 32'hFFFF_FFF9, 32'd2, res, lat, ndiv);
        n_tests++; if (res !== 32'hFFFF_FFFF || ndiv != 0 || lat != 1) begin
            n_fail++; $display("FAIL reuse_hit got %h/%0d/%0d want ffffffff/0/1", res, ndiv, lat);
        end
        pulse_reset();
        do_op(FN_REM, 32'hFFFF_FFF9, 32'd2, res, lat, ndiv);
        n_tests++; if (res !== 32'hFFFF_FFFF || ndiv != 1) begin n_fail++; $display("FAIL reuse_after_reset got %h/%0d want ffffffff/1", res, ndiv); end
        do_op(FN_REM, 32'hFFFF_FFF9, 32'd0, res, lat, ndiv);
        n_tests++; if (res !== 32'hFFFF_FFF9 || ndiv != 0) begin n_fail++; $display("FAIL reuse_zero_div got %h/%0d want fffffff9/0", res, ndiv); end
        do_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, ndiv);
        n_tests++; if (res !== 32'hFFFF_FFFD || ndiv != 0) begin n_fail++; $display("FAIL reuse_kept got %h/%0d want fffffffd/0", res, ndiv); end
        do_op(FN_DIVU, 32'hFFFF_FFF9, 32'd2, res, lat, ndiv);
        n_tests++; if (res !== 32'h7FFF_FFFC || ndiv != 1) begin n_fail++; $display("FAIL reuse_sign_miss got %h/%0d want 7ffffffc/1", res, ndiv); end
    endtask
`endif

    initial begin : main
        n_tests = 0;
        n_fail = 0;
        div_lat = 2;
        stall_req = 0;
        reset = 1'b1;
        bus.req_msg_fn = FN_DIV;
        bus.req_msg_a = 32'd0;
        bus.req_msg_b = 32'd0;
        bus.req_val = 1'b0;
        bus.resp_rdy = 1'b0;
        test_reset();
        test_basic();
        test_signed();
        test_unsigned();
        test_zero_div();
        test_backpressure();
        test_issue_stall();
        test_reset_in_wait();
`ifdef IMULDIV_DIV_FRONTEND_REUSE_EN
        test_reuse();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
